// File: rtl/timer_alarm_pkg.sv
// Shared definitions for the timer alarm stage: register offsets, ACTRL bit
// positions and the alarm FSM state type.
package timer_alarm_pkg;

  localparam logic [15:0] OFF_ALARMLO  = 16'hF040;
  localparam logic [15:0] OFF_ALARMHI  = 16'hF044;
  localparam logic [15:0] OFF_ACTRL    = 16'hF048;
  localparam logic [15:0] OFF_INT_RAW  = 16'hF04C;
  localparam logic [15:0] OFF_INT_ST   = 16'hF050;
  localparam logic [15:0] OFF_INT_CLR  = 16'hF054;
  localparam logic [15:0] OFF_PERIODLO = 16'hF058;
  localparam logic [15:0] OFF_PERIODHI = 16'hF05C;

  localparam int unsigned ACTRL_ALARM_EN    = 0;
  localparam int unsigned ACTRL_INT_ENA     = 1;
  localparam int unsigned ACTRL_AUTO_RELOAD = 2;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    FIRED    = 2'd2
  } alarm_state_t;

endpackage

// File: rtl/timer_alarm_cmp.sv
// Direction-aware unsigned comparator: flags when the live count has reached
// the alarm in the direction the timer is counting.
module timer_alarm_cmp #(
  parameter int unsigned CNT_W = 64
) (
  input  logic [CNT_W-1:0] count_i,
  input  logic [CNT_W-1:0] alarm_i,
  input  logic             up_i,
  input  logic             en_i,
  output logic             hit_o
);

  always_comb begin
    hit_o = en_i & (up_i ? (count_i >= alarm_i) : (count_i <= alarm_i));
  end

endmodule

// File: rtl/timer_alarm.sv
// Alarm/interrupt stage behind the MMIO timer. Optional auto-reload period
// registers are built when TIMER_ALARM_PERIODIC_EN is defined.
module timer_alarm
  import timer_alarm_pkg::*;
#(
  parameter logic [15:0] BASE_HI = 16'h3FF5,
  parameter int unsigned CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr_in,
  input  logic [31:0]      data_in,
  input  logic             wr_in,
  input  logic             rd_in,
  output logic             rd_valid_out,
  output logic [31:0]      data_out,
  input  logic [CNT_W-1:0] count_in,
  input  logic             count_up_in,
  input  logic             count_en_in,
  output logic             irq_out
);

  alarm_state_t     state_q;
  logic [CNT_W-1:0] alarm_q, alarm_d;
  logic             int_ena_q;
  logic             int_raw_q;
  logic             rd_valid_q;
  logic [31:0]      data_out_q;

  logic             page_hit;
  logic [15:0]      offset;
  logic             wr_hit, rd_hit;
  logic             actrl_wr, clr_wr;
  logic             hit, fire, auto_reload;
  logic [31:0]      rdata;

`ifdef TIMER_ALARM_PERIODIC_EN
  logic [CNT_W-1:0] period_q;
  logic             auto_reload_q;
  logic [CNT_W-1:0] reload_val;
`endif

  timer_alarm_cmp #(
    .CNT_W(CNT_W)
  ) u_cmp (
    .count_i(count_in),
    .alarm_i(alarm_q),
    .up_i   (count_up_in),
    .en_i   (count_en_in),
    .hit_o  (hit)
  );

  always_comb begin
    page_hit = (addr_in[31:16] == BASE_HI);
    offset   = addr_in[15:0];
    wr_hit   = wr_in & page_hit;
    rd_hit   = rd_in & page_hit;
    actrl_wr = wr_hit & (offset == OFF_ACTRL);
    clr_wr   = wr_hit & (offset == OFF_INT_CLR) & data_in[0];
    fire     = hit & (state_q == ARMED);
  end

`ifdef TIMER_ALARM_PERIODIC_EN
  always_comb begin
    auto_reload = auto_reload_q;
    reload_val  = count_up_in ? (alarm_q + period_q) : (alarm_q - period_q);
  end
`else
  always_comb begin
    auto_reload = 1'b0;
  end
`endif

  // Reload first so a same-cycle software write to either half takes priority.
  always_comb begin
    alarm_d = alarm_q;
`ifdef TIMER_ALARM_PERIODIC_EN
    if (fire && auto_reload) alarm_d = reload_val;
`endif
    if (wr_hit && offset == OFF_ALARMLO) alarm_d[31:0]  = data_in;
    if (wr_hit && offset == OFF_ALARMHI) alarm_d[63:32] = data_in;
  end

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_ALARMLO: rdata = alarm_q[31:0];
      OFF_ALARMHI: rdata = alarm_q[63:32];
      OFF_ACTRL: begin
        rdata[ACTRL_ALARM_EN] = (state_q == ARMED);
        rdata[ACTRL_INT_ENA]  = int_ena_q;
`ifdef TIMER_ALARM_PERIODIC_EN
        rdata[ACTRL_AUTO_RELOAD] = auto_reload_q;
`endif
      end
      OFF_INT_RAW: rdata[0] = int_raw_q;
      OFF_INT_ST:  rdata[0] = int_raw_q & int_ena_q;
`ifdef TIMER_ALARM_PERIODIC_EN
      OFF_PERIODLO: rdata = period_q[31:0];
      OFF_PERIODHI: rdata = period_q[63:32];
`endif
      default: rdata = '0;
    endcase
  end

  // ALARM_EN is not a separate flop: it reads as 1 exactly while ARMED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DISARMED;
      alarm_q    <= '0;
      int_ena_q  <= 1'b0;
      int_raw_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      data_out_q <= '0;
`ifdef TIMER_ALARM_PERIODIC_EN
      period_q      <= '0;
      auto_reload_q <= 1'b0;
`endif
    end else begin
      alarm_q <= alarm_d;

      if (actrl_wr) begin
        state_q   <= data_in[ACTRL_ALARM_EN] ? ARMED : DISARMED;
        int_ena_q <= data_in[ACTRL_INT_ENA];
`ifdef TIMER_ALARM_PERIODIC_EN
        auto_reload_q <= data_in[ACTRL_AUTO_RELOAD];
`endif
      end else if (fire && !auto_reload) begin
        state_q <= FIRED;
      end

      // A new hit beats a simultaneous clear.
      if (fire) begin
        int_raw_q <= 1'b1;
      end else if (clr_wr) begin
        int_raw_q <= 1'b0;
      end

`ifdef TIMER_ALARM_PERIODIC_EN
      if (wr_hit && offset == OFF_PERIODLO) period_q[31:0]  <= data_in;
      if (wr_hit && offset == OFF_PERIODHI) period_q[63:32] <= data_in;
`endif

      rd_valid_q <= rd_hit;
      if (rd_hit) data_out_q <= rdata;
    end
  end

  assign rd_valid_out = rd_valid_q;
  assign data_out     = data_out_q;
  assign irq_out      = int_raw_q & int_ena_q;

endmodule

// File: doc/timer_alarm.md
Name: timer_alarm

Overview:
- Alarm/interrupt stage directly downstream of the memory-mapped timer.
- Consumes the timer's live 64-bit count and count direction, and compares the count against a software-programmed 64-bit alarm.
- Latches an interrupt and drives irq_out to the core.
- Shares the timer's MMIO bus signals and 0x3FF5 page; decodes its own offsets, disjoint from the timer's.

Parameters:
- BASE_HI, 16'h3FF5, upper address half decoded for this block
- CNT_W, 64, counter/alarm width; fixed 64 in this revision

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- addr_in  in  32  MMIO address
- data_in  in  32  MMIO write data
- wr_in  in  1  write strobe, single-cycle
- rd_in  in  1  read strobe, single-cycle
- rd_valid_out  out  1  read data valid, one cycle after decoded read
- data_out  out  32  read data
- count_in  in  64  live timer count
- count_up_in  in  1  1 = timer counting up, 0 = counting down
- count_en_in  in  1  timer running
- irq_out  out  1  level interrupt to core

Behaviour:
- Reset (rst low, async): all registers 0, state DISARMED, irq_out 0, rd_valid_out 0, data_out 0.
- Register map (low 16 bits; decoded only when addr_in[31:16]==BASE_HI):
  - F040 ALARMLO (RW)
  - F044 ALARMHI (RW)
  - F048 ACTRL (RW): bit0 ALARM_EN, bit1 INT_ENA; other bits read 0.
  - F04C INT_RAW (RO): bit0 = alarm occurred.
  - F050 INT_ST (RO) = INT_RAW & INT_ENA.
  - F054 INT_CLR (WO, write 1 to bit0 clears INT_RAW; reads 0).
  - Writes to undecoded offsets are ignored.
- Read path: data_out and rd_valid_out registered, latency 1. rd_valid_out <= rd_in & page hit. Unmapped offsets in the page return 0. Off-page reads leave data_out unchanged and rd_valid_out 0.
- Compare (sub-module, combinational):
  - hit = count_en_in & (count_up_in ? count_in >= alarm : count_in <= alarm).
  - Unsigned 64-bit comparison.
- FSM:
  - DISARMED -> ARMED on ACTRL write with bit0=1.
  - ARMED -> FIRED on hit; INT_RAW set on the same edge, and hardware clears ALARM_EN.
  - FIRED -> ARMED on ACTRL write with bit0=1.
  - Any state -> DISARMED on ACTRL write with bit0=0.
- irq_out = INT_RAW & INT_ENA, driven from flops (no input-combinational path). Rises one cycle after the edge where hit is seen.
- Boundary conditions:
  - Hit while INT_RAW already 1: stays 1.
  - INT_CLR write and new hit on the same edge: set wins, INT_RAW stays 1.
  - ALARMLO/HI write while ARMED: new value used from the next cycle. Software writes HI then LO; no atomicity is provided.
  - Arming with an alarm already passed: fires on the first ARMED cycle.
  - count_in wrap-around (up: FFFF..F->0) is not special-cased.
  - count_en_in=0 suppresses hits.
  - Reset mid-FIRED: returns to DISARMED, INT_RAW cleared.

Optional Feature:
- Macro: TIMER_ALARM_PERIODIC_EN.
- Enabled:
  - Adds PERIODLO F058 and PERIODHI F05C (RW, reset 0).
  - Adds ACTRL bit2 AUTO_RELOAD.
  - On hit with AUTO_RELOAD=1: alarm <= alarm + period (up) or alarm - period (down), modulo 2^64. State stays ARMED; ALARM_EN is not cleared; INT_RAW is set.
  - Period 0 with AUTO_RELOAD: fires every enabled cycle.
- Disabled: those registers and bit2 read 0 and writes are ignored; one-shot behaviour only.

Decomposition:
- Package timer_alarm_pkg: register offset localparams, ACTRL bit indices, FSM enum type alarm_state_t {DISARMED, ARMED, FIRED}.
- Sub-module timer_alarm_cmp: direction-aware 64-bit comparator.
- Top module holds the registers, FSM, MMIO and irq logic.

Test Plan:
- Reset, then read F048/F04C -> rd_valid_out high 1 cycle later, data_out 0, irq_out 0.
- Alarm=100, ACTRL=3, count_up_in=1, count ramps 95->105 -> INT_RAW set when count_in=100; irq_out high next cycle; ACTRL bit0 reads 0.
- count_up_in=0, alarm=50, count 60 down -> hit at 50; with INT_ENA=0, INT_RAW=1 and INT_ST=0, irq_out stays 0.
- INT_CLR=1 written on the same cycle as a new hit (re-armed, count>=alarm) -> INT_RAW remains 1; a later clear with no hit drops irq_out the next cycle.
- Read at F000 page-hit -> data 0, valid 1. Read at 0x1234_F040 -> rd_valid_out 0, data_out unchanged.
- [TIMER_ALARM_PERIODIC_EN] alarm=10, period=10, AUTO_RELOAD, count up from 0 -> hits at 10, 20, 30; alarm reads 40 after third hit; state stays ARMED.
